// File: rtl/ub_pkg.sv
// Shared types and default sizing for the unified-buffer access scheduler.
package ub_pkg;
  localparam int DEF_ADDR_W    = 13;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_BURST_LEN = 4;

  typedef enum logic [1:0] {IDLE, RD_BURST, RD_DRAIN, WR_BURST} state_t;
  typedef enum logic [1:0] {REQ_W, REQ_I, REQ_S} req_class_t;
endpackage

// File: rtl/rr_arbiter3.sv
// 3-way round-robin arbiter; search starts at the pointer, pointer moves past the grantee on take.
module rr_arbiter3 import ub_pkg::*; (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] i_req,
  input  logic       i_take,
  output logic       o_gnt_vld,
  output req_class_t o_gnt
);
  logic [1:0] r_ptr;

  always_comb begin
    o_gnt_vld = 1'b0;
    o_gnt     = REQ_W;
    // Walk from farthest to nearest so the closest requester after the pointer wins.
    for (int k = 2; k >= 0; k--) begin
      int idx;
      idx = int'(r_ptr) + k;
      if (idx > 2) idx = idx - 3;
      if (i_req[idx]) begin
        o_gnt_vld = 1'b1;
        o_gnt     = req_class_t'(idx[1:0]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_ptr <= 2'd0;
    else if (i_take && o_gnt_vld)
      r_ptr <= (o_gnt == REQ_S) ? 2'd0 : 2'(o_gnt) + 2'd1;
  end
endmodule

// File: rtl/ub_access_scheduler.sv
// Sequences host writes and W/I/S tile bursts onto the single-port unified buffer.
module ub_access_scheduler import ub_pkg::*; #(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int BURST_LEN = DEF_BURST_LEN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] base_address,
  input  logic              load_weight,
  input  logic              load_input,
  input  logic              store,
  input  logic              host_wr_en,
  input  logic [ADDR_W-1:0] host_wr_addr,
  input  logic [DATA_W-1:0] host_wr_data,
  output logic              host_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] weight_data,
  output logic              weight_valid,
  output logic [DATA_W-1:0] input_data,
  output logic              input_valid,
  input  logic [DATA_W-1:0] result_data,
  output logic              result_pop,
  output logic              busy,
  output logic              op_done,
  output logic              cmd_drop
);
  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  state_t            r_state, w_state_n;
  req_class_t        r_cls, r_rd_cls, w_gnt;
  logic [2:0]        w_cmd, r_cmd_d, w_edge, r_pend;
  logic [ADDR_W-1:0] r_paddr [3];
  logic [ADDR_W-1:0] r_addr, w_beat_addr;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_drop, r_rd_vld, r_wr_done;
  logic              w_gnt_vld, w_take, w_host, w_last, w_rd, w_wr;

  assign w_cmd       = {store, load_input, load_weight};
  assign w_edge      = w_cmd & ~r_cmd_d;
  assign w_host      = (r_state == IDLE) && host_wr_en;
  assign w_take      = (r_state == IDLE) && !host_wr_en && w_gnt_vld;
  assign w_last      = (r_cnt == CNT_W'(BURST_LEN - 1));
  assign w_rd        = (r_state == RD_BURST);
  assign w_wr        = (r_state == WR_BURST);
  assign w_beat_addr = r_addr + ADDR_W'(r_cnt);

  rr_arbiter3 u_arb (
    .clk       (clk),
    .reset     (reset),
    .i_req     (r_pend),
    .i_take    (w_take),
    .o_gnt_vld (w_gnt_vld),
    .o_gnt     (w_gnt)
  );

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      IDLE:     if (w_take) w_state_n = (w_gnt == REQ_S) ? WR_BURST : RD_BURST;
      RD_BURST: if (w_last) w_state_n = RD_DRAIN;
      RD_DRAIN: w_state_n = IDLE;
      WR_BURST: if (w_last) w_state_n = IDLE;
      default:  w_state_n = IDLE;
    endcase
  end

  assign host_ready   = w_host;
  assign mem_en       = w_host | w_rd | w_wr;
  assign mem_we       = w_host | w_wr;
  assign mem_addr     = w_host ? host_wr_addr : ((w_rd | w_wr) ? w_beat_addr : '0);
  assign mem_wdata    = w_host ? host_wr_data : (w_wr ? result_data : '0);
  assign result_pop   = w_wr;
  // Read data returns one cycle after its address, so valid is the delayed read phase.
  assign weight_valid = r_rd_vld && (r_rd_cls == REQ_W);
  assign input_valid  = r_rd_vld && (r_rd_cls == REQ_I);
  assign weight_data  = weight_valid ? mem_rdata : '0;
  assign input_data   = input_valid ? mem_rdata : '0;
  assign op_done      = (r_state == RD_DRAIN) | r_wr_done;
  assign busy         = (r_state != IDLE) | (|r_pend);
  assign cmd_drop     = r_drop;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cmd_d   <= '0;
      r_pend    <= '0;
      for (int k = 0; k < 3; k++) r_paddr[k] <= '0;
      r_addr    <= '0;
      r_cnt     <= '0;
      r_cls     <= REQ_W;
      r_rd_cls  <= REQ_W;
      r_drop    <= 1'b0;
      r_rd_vld  <= 1'b0;
      r_wr_done <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_cmd_d   <= w_cmd;
      r_rd_vld  <= w_rd;
      r_rd_cls  <= r_cls;
      r_wr_done <= w_wr && w_last;
      // Grant clears first; an edge on a slot that was already full is dropped.
      for (int k = 0; k < 3; k++) begin
        if (w_take && (w_gnt == req_class_t'(k))) r_pend[k] <= 1'b0;
        if (w_edge[k]) begin
          if (r_pend[k]) begin
            r_drop <= 1'b1;
          end else begin
            r_pend[k]  <= 1'b1;
            r_paddr[k] <= base_address;
          end
        end
      end
      if (w_take) begin
        r_addr <= r_paddr[w_gnt];
        r_cnt  <= '0;
        r_cls  <= w_gnt;
      end else if (w_rd || w_wr) begin
        r_cnt  <= w_last ? '0 : r_cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: doc/ub_access_scheduler.md
Name: ub_access_scheduler

Overview:
Arbitrates and sequences all accesses to the single-port unified buffer (UB) SRAM. Requesters are host writes, weight fetch, input fetch and result store. It sits between control_unit (load_weight / load_input / store pulses plus base_address) and the UB. It turns each command into a BURST_LEN-word burst feeding the weight/input skew buffers or draining the accumulator results.

Parameters:
ADDR_W, 13, UB address width; matches control_unit base_address.
DATA_W, 8, UB word width.
BURST_LEN, 4, words per command (one 2x2 tile).

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
base_address  input  ADDR_W  burst start address, sampled with any command pulse
load_weight  input  1  weight-fetch command (level or pulse; rising edge = one command)
load_input  input  1  input-fetch command (rising edge = one command)
store  input  1  result-store command (rising edge = one command)
host_wr_en  input  1  host write request
host_wr_addr  input  ADDR_W  host write address
host_wr_data  input  DATA_W  host write data
host_ready  output  1  host write accepted this cycle
mem_en  output  1  UB enable
mem_we  output  1  UB write enable
mem_addr  output  ADDR_W  UB address
mem_wdata  output  DATA_W  UB write data
mem_rdata  input  DATA_W  UB read data, 1-cycle latency
weight_data  output  DATA_W  fetched weight word
weight_valid  output  1  weight_data valid
input_data  output  DATA_W  fetched input word
input_valid  output  1  input_data valid
result_data  input  DATA_W  accumulator result word
result_pop  output  1  result_data consumed this cycle
busy  output  1  burst in progress or command pending
op_done  output  1  one-cycle pulse after last beat of a burst
cmd_drop  output  1  sticky: command arrived while same class already pending

Behaviour:
- Reset (synchronous): state=IDLE; pending flags clear; RR pointer=WEIGHT; beat counter=0; cmd_drop=0. All other outputs are 0.
- Command capture:
  - Each class (W, I, S) has one pending slot holding {flag, addr}.
  - A rising edge of the command signal sets the flag and latches base_address.
  - A rising edge while the flag is already set is ignored and sets cmd_drop.
  - Simultaneous edges on several classes each latch base_address of that cycle.
- States: IDLE, RD_BURST, RD_DRAIN, WR_BURST.
- IDLE:
  - If host_wr_en: host_ready=1, mem_en=1, mem_we=1, mem_addr/mem_wdata from the host ports. Stay IDLE. The host has priority over pending commands.
  - Otherwise, if any flag is set: grant round-robin starting at the pointer (order W→I→S). Clear that flag, load addr and counter=0, and advance the pointer to grantee+1.
  - W or I → RD_BURST; S → WR_BURST.
- RD_BURST:
  - mem_en=1, mem_we=0, mem_addr=addr+counter (mod 2^ADDR_W, wraps).
  - counter increments; after beat BURST_LEN-1 → RD_DRAIN.
- Read data return: the cycle after each read beat, the grantee's *_data=mem_rdata and its *_valid=1. This gives exactly BURST_LEN consecutive valid cycles, lagging addresses by 1.
- RD_DRAIN: issues no access; delivers the last word; op_done=1; → IDLE.
- WR_BURST:
  - mem_en=1, mem_we=1, mem_wdata=result_data, result_pop=1, mem_addr=addr+counter.
  - After beat BURST_LEN-1, op_done is asserted the next cycle (in IDLE) → IDLE.
- host_ready=0 and host writes stall in every non-IDLE state. Bursts are never preempted.
- busy = (state≠IDLE) | any pending flag.
- Commands arriving during a burst are captured and served at the next IDLE.
- Reset mid-burst aborts immediately: no further mem_en, valids drop next edge, pending commands are lost.
- Burst-to-burst turnaround is at least 1 IDLE cycle; worst-case W-command latency is 2 other bursts plus host traffic.

Decomposition:
- Package ub_pkg: ADDR_W/DATA_W/BURST_LEN defaults, the state_t enum (IDLE, RD_BURST, RD_DRAIN, WR_BURST) and the req_class_t enum (REQ_W, REQ_I, REQ_S).
- Sub-module rr_arbiter3 (3-way round-robin, pointer update on grant) is natural. Command edge detection/pending slots stay inline.

Test Plan:
- Reset then load_weight with base_address=0x010, UB holding 0x11..0x14 → mem reads at 0x010..0x013 on 4 consecutive cycles; weight_valid high for 4 cycles with 0x11,0x12,0x13,0x14, lagging by 1; op_done pulses once; input_valid stays 0.
- load_weight, load_input, store on the same cycle (addrs 0x000, 0x020, 0x040) → served in order W, I, S; next W+I+S burst after pointer=S is served I-first only if W absent (check pointer rotation); cmd_drop=0.
- host_wr_en held during a store burst at 0x1FFE (wraps to 0x1FFF, 0x0000, 0x0001) → host_ready=0 throughout; mem_addr wraps correctly; 4 result_pop cycles; host write to 0x005 issues in the first IDLE cycle.
- Second load_input edge while an input command is pending → cmd_drop=1 and stays 1; only one input burst is executed.
- Continuous host_wr_en in IDLE with pending load_weight → weight burst is starved until host_wr_en drops, then starts next cycle.
- Assert reset on the 2nd beat of a read burst → next cycle mem_en=0, all valids 0, busy=0, pending flags clear.
